mac_cluster_pipe: RTL

Parametrised successor to the fixed four-lane MAC quad-cluster. It provides LANES signed multiply-accumulate lanes with valid/ready handshakes on input and output, and a 2-stage pipeline. A run is configured with initial accumulator values, a beat count, and a mode: independent lanes, or dot-product across all lanes into lane 0, optionally saturating. It sits between the operand fabric and the result collector, replacing hard-wired quad instances.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_lane_acc.sv | 39 +++
 rtl/mac_cluster_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared widths, mode bit positions and state encoding for the MAC cluster.
package mac_pkg;
  localparam int MAC_LANES     = 4;
  localparam int MAC_MIN_WIDTH = 8;
  localparam int MAC_ACC_WIDTH = 32;
  localparam int MAC_LEN_WIDTH = 16;

  localparam int MODE_DOT = 0;
  localparam int MODE_SAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } mac_state_e;
endpackage

// File: rtl/mac_lane_acc.sv
// One lane's accumulator: stage-2 add with optional two's-complement clamp.
// Latency: 1 cycle from add_en to acc; no backpressure, the parent gates add_en.
module mac_lane_acc #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] init,
  input  logic                 add_en,
  input  logic [ACC_WIDTH-1:0] addend,
  input  logic                 sat,
  output logic [ACC_WIDTH-1:0] acc
);
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum;

  always_comb begin
    sum   = {acc_q[ACC_WIDTH-1], acc_q} + {addend[ACC_WIDTH-1], addend};
    acc_d = acc_q;
    if (load) begin
      acc_d = init;
    end else if (add_en) begin
      acc_d = sum[ACC_WIDTH-1:0];
      // Top two bits of the extended sum disagree only on signed overflow.
      if (sat && (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])) begin
        acc_d = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/mac_cluster_pipe.sv
// LANES-wide signed MAC cluster, independent or dot-product mode, optional saturation.
// Latency: last beat accepted at edge N -> out_valid after N+2; out held until out_ready.
module mac_cluster_pipe
  import mac_pkg::*;
#(
  parameter int LANES     = MAC_LANES,
  parameter int MIN_WIDTH = MAC_MIN_WIDTH,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int LEN_WIDTH = MAC_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  input  logic [LANES*ACC_WIDTH-1:0] cfg_init,
  input  logic [1:0]                 cfg_mode,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*MIN_WIDTH-1:0] a,
  input  logic [LANES*MIN_WIDTH-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] out
);
  localparam int PROD_W = 2 * MIN_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  mac_state_e           state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic                 s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s2_last_q, s2_last_d;
  logic                 load, in_fire;
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [SUM_W-1:0]  tree_sum;

  assign cnt_inc = cnt_q + 1'b1;
  assign in_fire = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    s1_vld_d  = 1'b0;
    s1_last_d = 1'b0;
    s2_last_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          mode_d  = cfg_mode;
          len_d   = cfg_len;
          cnt_d   = '0;
          load    = 1'b1;
          state_d = (cfg_len == '0) ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = (cnt_q < len_q);
        if (in_valid && in_ready) begin
          cnt_d     = cnt_inc;
          s1_vld_d  = 1'b1;
          s1_last_d = (cnt_inc == len_q);
        end
        // The last-beat marker rides alongside the data so DRAIN waits for stage 2.
        s2_last_d = s1_last_q;
        if (s2_last_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = prod_q[i];
      if (in_fire) begin
        prod_d[i] = PROD_W'($signed(a[i*MIN_WIDTH +: MIN_WIDTH]))
                  * PROD_W'($signed(b[i*MIN_WIDTH +: MIN_WIDTH]));
      end
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) tree_sum = tree_sum + SUM_W'(prod_q[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_last_q <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s2_last_q <= s2_last_d;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ACC_WIDTH-1:0] addend;
    logic                 add_en;

    // In dot mode lane 0 takes the tree sum and the other lanes keep their init.
    assign addend = (mode_q[MODE_DOT] && (i == 0)) ? ACC_WIDTH'(tree_sum)
                                                   : ACC_WIDTH'(prod_q[i]);
    assign add_en = s1_vld_q && (!mode_q[MODE_DOT] || (i == 0));

    mac_lane_acc #(.ACC_WIDTH(ACC_WIDTH)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .init   (cfg_init[i*ACC_WIDTH +: ACC_WIDTH]),
      .add_en (add_en),
      .addend (addend),
      .sat    (mode_q[MODE_SAT]),
      .acc    (out[i*ACC_WIDTH +: ACC_WIDTH])
    );
  end
endmodule
